// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: 4-cycle LOAD/EXEC/WB sequencer with register file and flags; ALU_ISSUE_IMM_EN enables immediate operand B
module alu_issue_ctrl #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int RA_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_opcode,
  input  logic [RA_W-1:0]  in_rd,
  input  logic [RA_W-1:0]  in_rs,
  input  logic             in_imm_en,
  input  logic [WIDTH-1:0] in_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [5:0]       alu_opcode,
  output logic             alu_c,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             alu_c_in,
  input  logic             alu_o,
  output logic             done,
  output logic             err,
  output logic [3:0]       flags,
  input  logic [RA_W-1:0]  dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);
  localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_EXEC = 2'd2, S_WB = 2'd3;
  localparam logic [5:0] OP_ADD = 6'b001001, OP_SUB = 6'b001010, OP_LSR = 6'b001011, OP_LSL = 6'b001100;
  localparam logic [5:0] OP_MOV = 6'b001111, OP_MUL = 6'b010000, OP_DIV = 6'b010001, OP_MOD = 6'b010010;
  localparam logic [5:0] OP_AND = 6'b010011, OP_OR = 6'b010100, OP_XOR = 6'b010101, OP_NOT = 6'b010110;
  localparam logic [5:0] OP_CMP = 6'b010111, OP_TST = 6'b011000, OP_INC = 6'b011001, OP_DEC = 6'b011010;
  logic [1:0]       state;
  logic [WIDTH-1:0] regs [NREGS];
  logic [5:0]       op_q;
  logic [RA_W-1:0]  rd_q, rs_q;
  logic [WIDTH-1:0] b_val, res_q;
  logic [3:0]       fl_q, mask_q, mask_c;
  logic             err_q, wb_q, err_c, wb_c;
`ifdef ALU_ISSUE_IMM_EN
  logic             imm_en_q;
  logic [WIDTH-1:0] imm_q;
  assign b_val = imm_en_q ? imm_q : regs[rs_q];
`else
  logic unused_imm;
  assign unused_imm = ^{in_imm_en, in_imm};
  assign b_val = regs[rs_q];
`endif
  assign in_ready = state == S_IDLE;
  assign dbg_data = regs[dbg_addr];
  assign err_c = !(op_q >= OP_ADD && op_q <= OP_DEC) || ((op_q == OP_DIV || op_q == OP_MOD) && b_val == '0);
  assign wb_c = !err_c && op_q != OP_CMP && op_q != OP_TST;
  // flag write mask in {Z,N,C,O} order; rejected instructions touch nothing
  always_comb begin
    case (op_q)
      OP_ADD, OP_SUB, OP_CMP, OP_INC, OP_DEC: mask_c = 4'b1111;
      OP_MOV, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_TST, OP_MUL, OP_DIV: mask_c = 4'b1100;
      OP_LSR, OP_LSL: mask_c = 4'b1010;
      OP_MOD: mask_c = 4'b1000;
      default: mask_c = 4'b0000;
    endcase
    if (err_c) mask_c = 4'b0000;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      flags <= '0;
      done <= 1'b0;
      err <= 1'b0;
      alu_a <= '0;
      alu_b <= '0;
      alu_opcode <= '0;
      alu_c <= 1'b0;
      op_q <= '0;
      rd_q <= '0;
      rs_q <= '0;
      res_q <= '0;
      fl_q <= '0;
      mask_q <= '0;
      err_q <= 1'b0;
      wb_q <= 1'b0;
`ifdef ALU_ISSUE_IMM_EN
      imm_en_q <= 1'b0;
      imm_q <= '0;
`endif
    end else begin
      done <= state == S_EXEC;
      err <= state == S_EXEC && err_q;
      case (state)
        S_IDLE: if (in_valid) begin
          op_q <= in_opcode;
          rd_q <= in_rd;
          rs_q <= in_rs;
`ifdef ALU_ISSUE_IMM_EN
          imm_en_q <= in_imm_en;
          imm_q <= in_imm;
`endif
          state <= S_LOAD;
        end
        S_LOAD: begin
          alu_a <= regs[rd_q];
          alu_b <= b_val;
          alu_opcode <= op_q;
          alu_c <= flags[1];
          err_q <= err_c;
          wb_q <= wb_c;
          mask_q <= mask_c;
          state <= S_EXEC;
        end
        S_EXEC: begin
          res_q <= alu_result;
          fl_q <= {alu_z, alu_n, alu_c_in, alu_o};
          state <= S_WB;
        end
        default: begin
          if (wb_q) regs[rd_q] <= res_q;
          flags <= (fl_q & mask_q) | (flags & ~mask_q);
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule
